regfile_writeback_scheduler: RTL

Controller sitting in front of the CPU register file. It owns the single write port, arbitrating writebacks from NUM_SOURCES functional units with round-robin priority. It keeps a per-register busy scoreboard so the issue stage stalls on RAW/WAW hazards until the pending write is actually committed to the register file.

---
 rtl/regfile_writeback_scheduler.sv | 111 +++++++++++
 1 files changed

// File: rtl/regfile_writeback_scheduler.sv
// Register-file write-port owner: round-robin writeback arbitration across
// the functional units, plus a per-register busy scoreboard that stalls the
// issue stage on RAW/WAW hazards until the pending write has landed.
module regfile_writeback_scheduler #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32,
    parameter int NUM_SOURCES   = 2,
    localparam int REG_W        = $clog2(NUM_REGISTERS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              issue_valid,
    output logic                              issue_ready,
    input  logic [REG_W-1:0]                  issue_rs1,
    input  logic [REG_W-1:0]                  issue_rs2,
    input  logic [REG_W-1:0]                  issue_rd,
    input  logic [NUM_SOURCES-1:0]            wb_valid,
    output logic [NUM_SOURCES-1:0]            wb_ready,
    input  logic [NUM_SOURCES*REG_W-1:0]      wb_rd,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] wb_data,
    output logic [REG_W-1:0]                  write_register,
    output logic [DATA_WIDTH-1:0]             write_data,
    output logic [NUM_REGISTERS-1:0]          busy
);

    localparam int SRC_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    logic [SRC_W-1:0]            pointer;
    logic [SRC_W-1:0]            scan_idx;
    logic [SRC_W-1:0]            grant_idx;
    logic                        grant_any;
    logic [NUM_SOURCES-1:0]      grant;
    logic                        issue_fire;
    logic [NUM_REGISTERS-1:0]    busy_next;
    logic [REG_W-1:0]            src_rd   [NUM_SOURCES];
    logic [DATA_WIDTH-1:0]       src_data [NUM_SOURCES];

    genvar s;
    generate
        for (s = 0; s < NUM_SOURCES; s++) begin : g_unpack
            assign src_rd[s]   = wb_rd[s*REG_W +: REG_W];
            assign src_data[s] = wb_data[s*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Issue may proceed only when none of its registers has a write in flight;
    // uses the registered scoreboard only, so a same-cycle commit does not bypass.
    always_comb begin
        issue_ready = rst & ~(busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]);
        issue_fire  = issue_valid & issue_ready;
    end

    // Round-robin scan starting just after the last granted source, wrapping.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = '0;
        for (int i = 1; i <= NUM_SOURCES; i++) begin
            scan_idx = SRC_W'((int'(pointer) + i) % NUM_SOURCES);
            if (!grant_any && wb_valid[scan_idx]) begin
                grant_any       = 1'b1;
                grant_idx       = scan_idx;
                grant[scan_idx] = 1'b1;
            end
        end
        if (!rst) begin
            grant     = '0;
            grant_any = 1'b0;
        end
        wb_ready = grant;
    end

    // Granted writeback is registered onto the write port for one cycle; idle cycles drive index 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pointer        <= SRC_W'(NUM_SOURCES - 1);
            write_register <= '0;
            write_data     <= '0;
        end else if (grant_any) begin
            pointer        <= grant_idx;
            write_register <= src_rd[grant_idx];
            write_data     <= src_data[grant_idx];
        end else begin
            write_register <= '0;
            write_data     <= '0;
        end
    end

    // Scoreboard update: clear on the edge the data lands, set on issue; register 0 never tracked.
    always_comb begin
        busy_next = busy;
        if (write_register != '0) begin
            busy_next[write_register] = 1'b0;
        end
        if (issue_fire && issue_rd != '0) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule
